// File: rtl/tetris_pkg.sv
// Shared types, LFSR taps and small helpers for the tetrimino sequencer.
package tetris_pkg;

    typedef enum logic [2:0] {P_NONE, P_L, P_O, P_S, P_T, P_Z, P_I, P_J} piece_t;

    typedef enum logic {S_FILL, S_FULL} seq_state_t;

    localparam logic [15:0] SEED_DEFAULT_C = 16'hACE1;

    // Feedback taps of the 16-bit shift-left LFSR
    localparam int unsigned TAP_A = 15;
    localparam int unsigned TAP_B = 13;
    localparam int unsigned TAP_C = 12;
    localparam int unsigned TAP_D = 10;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[TAP_A] ^ l[TAP_B] ^ l[TAP_C] ^ l[TAP_D]};
    endfunction

    // One-hot bag bit for a piece code; P_NONE maps to no bit
    function automatic logic [6:0] piece_bit(input piece_t p);
        logic [6:0] b;
        b = '0;
        for (int unsigned i = 1; i <= 7; i++) begin
            if (3'(i) == p) b[i-1] = 1'b1;
        end
        return b;
    endfunction

    // Lowest piece code whose bag bit is still clear
    function automatic piece_t lowest_unused(input logic [6:0] mask);
        piece_t code;
        code = P_NONE;
        for (int unsigned i = 7; i > 0; i--) begin
            if (!mask[i-1]) code = piece_t'(3'(i));
        end
        return code;
    endfunction

endpackage

// File: rtl/tetris_lfsr16.sv
// Reusable 16-bit Fibonacci LFSR with synchronous parallel load.
module tetris_lfsr16
    import tetris_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = SEED_DEFAULT_C
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        load,
    input  logic [15:0] loadVal,
    output logic [15:0] state
);

    // Load has priority over stepping
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= RESET_VAL;
        end else if (load) begin
            state <= loadVal;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/tetrimino_sequencer.sv
// Piece source for the tetrimino creator: current piece plus one-deep preview.
// Optional macro TETRIS_SEQ_BAG_EN selects 7-bag mode; default is repeat-free mode.
module tetrimino_sequencer
    import tetris_pkg::*;
#(
    parameter logic [15:0] SEED_DEFAULT = SEED_DEFAULT_C,
    parameter int unsigned MAX_TRIES    = 8
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [15:0] seedIn,
    input  logic        seedLoad,
    input  logic        pieceReq,
    output logic        pieceValid,
    output logic [2:0]  typeOut,
    output logic [2:0]  nextType
);

    logic [15:0] lfsr_state;
    logic [15:0] seed_val;
    seq_state_t  state;
    piece_t      cur_q;
    piece_t      next_q;
    logic [3:0]  tries;

    piece_t      cand;
    piece_t      fallback;
    piece_t      accept_code;
    piece_t      cur_d;
    piece_t      next_d;
    logic        pop;
    logic        draw_en;
    logic        cand_ok;
    logic        accept;

    assign seed_val = (seedIn == '0) ? SEED_DEFAULT : seedIn;

    tetris_lfsr16 #(
        .RESET_VAL(SEED_DEFAULT)
    ) u_lfsr (
        .clk    (clk),
        .nReset (nReset),
        .load   (seedLoad),
        .loadVal(seed_val),
        .state  (lfsr_state)
    );

    assign cand = piece_t'(lfsr_state[2:0]);
    assign pop  = pieceReq && pieceValid;
    // A pop from FULL frees a slot on the same edge, so that cycle still draws
    assign draw_en = (state == S_FILL) || pop;

`ifdef TETRIS_SEQ_BAG_EN
    logic [6:0] used_mask;
    logic [6:0] mask_set;

    assign cand_ok  = (cand != P_NONE) && ((used_mask & piece_bit(cand)) == '0);
    assign fallback = lowest_unused(used_mask);
    assign mask_set = used_mask | piece_bit(accept_code);
`else
    piece_t last_type;

    assign cand_ok  = (cand != P_NONE) && (cand != last_type);
    assign fallback = (last_type == P_J) ? P_L : piece_t'(3'(last_type + 3'd1));
`endif

    assign accept      = draw_en && (cand_ok || (tries == 4'(MAX_TRIES)));
    assign accept_code = cand_ok ? cand : fallback;

    // Pop first, then place the accepted code in the first free slot
    always_comb begin
        cur_d  = cur_q;
        next_d = next_q;
        if (pop) begin
            cur_d  = next_q;
            next_d = P_NONE;
        end
        if (accept) begin
            if (cur_d == P_NONE) cur_d = accept_code;
            else                 next_d = accept_code;
        end
    end

    // Slot registers, FILL/FULL state, retry counter and draw history
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= S_FILL;
            cur_q      <= P_NONE;
            next_q     <= P_NONE;
            pieceValid <= 1'b0;
            tries      <= '0;
`ifdef TETRIS_SEQ_BAG_EN
            used_mask  <= '0;
`else
            last_type  <= P_NONE;
`endif
        end else begin
            cur_q      <= cur_d;
            next_q     <= next_d;
            pieceValid <= (cur_d != P_NONE);
            state      <= ((cur_d != P_NONE) && (next_d != P_NONE)) ? S_FULL : S_FILL;
            if (!draw_en || accept) tries <= '0;
            else                    tries <= tries + 4'd1;
            if (accept) begin
`ifdef TETRIS_SEQ_BAG_EN
                used_mask <= (mask_set == '1) ? '0 : mask_set;
`else
                last_type <= accept_code;
`endif
            end
        end
    end

    assign typeOut  = cur_q;
    assign nextType = next_q;

endmodule
